// File: rtl/vga_rx.sv
// vga_rx: VGA pin receiver; recovers h/v position from hsync/vsync, locks after one good frame, emits active pixels.
// Latency: 3 clocks from pins to pix_* (two synchroniser flops plus the output register).
// Backpressure: none; one pixel per clock, the stream cannot be stalled.
// Ports: CLK, RST (async active-high); h_sync_in/v_sync_in/rgb_in pins;
//        pix_valid/pix_x/pix_y/pix_rgb/frame_start pixel stream; locked/err_cnt/line_len status.
module vga_rx #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [2:0]  rgb_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_cnt,
    output logic [10:0] line_len
);

    localparam logic [10:0] H_TOT = 11'(H_TOTAL);
    localparam logic [10:0] H_A0  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_A1  = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_TOT = 11'(V_TOTAL);
    localparam logic [9:0]  V_A0  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_A1  = 10'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [1:0]  hs_sync, vs_sync;
    logic        hs_prev, vs_prev;
    logic [2:0]  rgb_s1, rgb_s2;
    logic [10:0] h_cnt, h_inc, h_idx, h_off;
    logic [9:0]  v_cnt, v_inc, v_idx, v_off;
    logic        line_seen;
    logic        h_edge, v_edge, line_chk, line_bad, frame_bad, mismatch, drop, pix_act;

    // Two-flop synchronisers, plus one extra stage on the syncs for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hs_sync <= {2{~SYNC_POL}};
            vs_sync <= {2{~SYNC_POL}};
            hs_prev <= ~SYNC_POL;
            vs_prev <= ~SYNC_POL;
            rgb_s1  <= '0;
            rgb_s2  <= '0;
        end else begin
            hs_sync <= {hs_sync[0], h_sync_in};
            vs_sync <= {vs_sync[0], v_sync_in};
            hs_prev <= hs_sync[1];
            vs_prev <= vs_sync[1];
            rgb_s1  <= rgb_in;
            rgb_s2  <= rgb_s1;
        end
    end

    // h_cnt/v_cnt hold the position of the previous sample; h_idx/v_idx are the
    // position of the sample currently leaving the synchroniser.
    always_comb begin
        h_edge    = (hs_sync[1] == SYNC_POL) && (hs_prev != SYNC_POL);
        v_edge    = (vs_sync[1] == SYNC_POL) && (vs_prev != SYNC_POL);
        h_inc     = (h_cnt == 11'h7FF) ? h_cnt : h_cnt + 11'd1;
        v_inc     = (v_cnt == 10'h3FF) ? v_cnt : v_cnt + 10'd1;
        h_idx     = h_edge ? 11'd0 : h_inc;
        v_idx     = v_edge ? 10'd0 : (h_edge ? v_inc : v_cnt);
        h_off     = h_idx - H_A0;
        v_off     = v_idx - V_A0;
        // h_inc doubles as the saturated length of the line that just ended.
        line_chk  = h_edge && line_seen;
        line_bad  = line_chk && (h_inc != H_TOT);
        frame_bad = v_edge && (({1'b0, v_cnt} + 11'd1) != V_TOT);
        mismatch  = line_bad || frame_bad;
    end

    always_comb begin
        state_nxt = state;
        drop      = 1'b0;
        case (state)
            SEARCH: if (v_edge) state_nxt = VERIFY;
            VERIFY: begin
                if (mismatch) begin
                    state_nxt = SEARCH;
                    drop      = 1'b1;
                end else if (v_edge) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    state_nxt = SEARCH;
                    drop      = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // A mismatching edge never produces a pixel even though the state is still LOCKED.
    always_comb begin
        pix_act = (state == LOCKED) && !mismatch
               && (h_idx >= H_A0) && (h_idx < H_A1)
               && (v_idx >= V_A0) && (v_idx < V_A1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= SEARCH;
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_seen   <= 1'b0;
            line_len    <= '0;
            err_cnt     <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            h_cnt     <= h_idx;
            v_cnt     <= v_idx;
            line_seen <= line_seen || h_edge;
            if (line_chk) line_len <= h_inc;
            if (drop && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            pix_valid   <= pix_act;
            frame_start <= pix_act && (h_idx == H_A0) && (v_idx == V_A0);
            if (pix_act) begin
                pix_x   <= h_off[9:0];
                pix_y   <= v_off;
                pix_rgb <= rgb_s2;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule
